// File: rtl/csr_uart_rx_if.sv
// CSR bus bundle for csr_uart_rx: request signals from the core, response back.
interface csr_uart_rx_if;
    logic        read;
    logic [2:0]  modify;
    logic [31:0] wdata;
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        valid;

    modport master (output read, output modify, output wdata, output addr,
                    input  rdata, input  valid);
    modport slave  (input  read, input  modify, input  wdata, input  addr,
                    output rdata, output valid);
endinterface

// File: rtl/csr_uart_rx.sv
// 8N1 UART receiver behind a CSR read port; pops return the byte or -1 when empty.
// Define CSR_UART_RX_FIFO_EN to replace the single holding register with a 4-entry FIFO.
module csr_uart_rx #(
    parameter logic [11:0] BASE_ADDR = 12'hBC0,
    parameter int unsigned DIVISOR   = 8
) (
    input  logic         clk,
    input  logic         rst,
    csr_uart_rx_if.slave bus,
    input  logic         rx,
    output logic         irq
);
    localparam int unsigned DIV_W  = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned BIT_W  = 3;
    localparam logic [DIV_W-1:0] HALF_LOAD = DIV_W'(DIVISOR / 2);
    // Reload one short so successive samples land exactly DIVISOR cycles apart.
    localparam logic [DIV_W-1:0] BIT_LOAD  = DIV_W'(DIVISOR - 1);

    typedef enum logic [2:0] {S_ARM, S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                rx_m, rx_s;
    logic                tick_c, push_c, ferr_set_c;

    logic                rd_hit_c, pop_c, avail_c, ovr_set_c, irq_d_c;
    logic [DATA_W-1:0]   head_c;
    logic                ovr_q, ferr_q;

    logic                unused_bus;
    assign unused_bus = ^{bus.modify, bus.wdata};

    // Two-flop synchroniser; resets low so a line held low stays in ARM.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b0;
            rx_s <= 1'b0;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ARM;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    assign tick_c = (div_q == '0);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        push_c     = 1'b0;
        ferr_set_c = 1'b0;
        case (state_q)
            S_ARM: begin
                if (rx_s) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    div_d   = HALF_LOAD;
                end
            end
            S_START: begin
                if (!tick_c) begin
                    div_d = div_q - DIV_W'(1);
                end else if (!rx_s) begin
                    state_d = S_DATA;
                    div_d   = BIT_LOAD;
                    bit_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (!tick_c) begin
                    div_d = div_q - DIV_W'(1);
                end else begin
                    shift_d = {rx_s, shift_q[DATA_W-1:1]};
                    div_d   = BIT_LOAD;
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(DATA_W - 1)) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (!tick_c) begin
                    div_d = div_q - DIV_W'(1);
                end else if (rx_s) begin
                    push_c  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    ferr_set_c = 1'b1;
                    state_d    = S_ARM;
                end
            end
            default: state_d = S_ARM;
        endcase
    end

    assign rd_hit_c = bus.read && (bus.addr == BASE_ADDR);
    assign pop_c    = rd_hit_c && avail_c;

`ifdef CSR_UART_RX_FIFO_EN
    localparam int unsigned PTR_W = 2;
    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(4);

    logic [DATA_W-1:0] mem_q [4];
    logic [PTR_W-1:0]  wp_q, rp_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push_ok_c;

    assign avail_c   = (cnt_q != '0);
    assign head_c    = mem_q[rp_q];
    assign push_ok_c = push_c && ((cnt_q != DEPTH) || pop_c);
    assign ovr_set_c = push_c && !push_ok_c;
    assign cnt_d     = cnt_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);
    assign irq_d_c   = (cnt_d != '0);

    always_ff @(posedge clk) begin
        if (push_ok_c) mem_q[wp_q] <= shift_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok_c) wp_q <= wp_q + PTR_W'(1);
            if (pop_c)     rp_q <= rp_q + PTR_W'(1);
            cnt_q <= cnt_d;
        end
    end
`else
    logic              full_q;
    logic [DATA_W-1:0] hold_q;

    assign avail_c   = full_q;
    assign head_c    = hold_q;
    assign ovr_set_c = push_c && full_q && !pop_c;
    assign irq_d_c   = push_c || (full_q && !pop_c);

    // A push while full keeps the old byte unless the same cycle pops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            hold_q <= '0;
        end else begin
            if (push_c && (!full_q || pop_c)) hold_q <= shift_q;
            full_q <= irq_d_c;
        end
    end
`endif

    // Flags raised in the popping cycle survive the pop's clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
            irq       <= 1'b0;
            bus.valid <= 1'b0;
            bus.rdata <= '0;
        end else begin
            ovr_q     <= ovr_set_c  || (ovr_q  && !pop_c);
            ferr_q    <= ferr_set_c || (ferr_q && !pop_c);
            irq       <= irq_d_c;
            bus.valid <= rd_hit_c;
            if (!rd_hit_c)    bus.rdata <= '0;
            else if (avail_c) bus.rdata <= {22'b0, ovr_q, ferr_q, head_c};
            else              bus.rdata <= '1;
        end
    end
endmodule

// File: tb/tb_csr_uart_rx.sv
// Directed bench for csr_uart_rx at DIVISOR=8: framing, overrun, glitch, reset and decode cases.
module tb_csr_uart_rx;
    localparam int unsigned DIVISOR = 8;
    localparam logic [11:0] BASE = 12'hBC0;

    logic clk = 1'b0;
    logic rst;
    logic rx;
    logic irq;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] rd;
    logic        vl;

    csr_uart_rx_if bus ();

    csr_uart_rx #(.BASE_ADDR(BASE), .DIVISOR(DIVISOR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .rx  (rx),
        .irq (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic hold_bit(input logic b);
        rx = b;
        repeat (DIVISOR) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
        hold_bit(stop);
    endtask

    task automatic csr_read(input logic [11:0] a, output logic [31:0] d, output logic v);
        bus.read = 1'b1;
        bus.addr = a;
        @(negedge clk);
        bus.read = 1'b0;
        bus.addr = '0;
        d = bus.rdata;
        v = bus.valid;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        bus.read = 1'b0;
        bus.modify = 3'd0;
        bus.wdata = '0;
        bus.addr = '0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_rdata", bus.rdata, 32'h0);
        check("reset_valid", 32'(bus.valid), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        repeat (10) @(negedge clk);

        // single byte, then empty read
        send(8'h55, 1'b1);
        check("irq_after_55", 32'(irq), 32'h1);
        csr_read(BASE, rd, vl);
        check("rd_55", rd, 32'h0000_0055);
        check("valid_55", 32'(vl), 32'h1);
        check("irq_after_pop", 32'(irq), 32'h0);
        csr_read(BASE, rd, vl);
        check("rd_empty", rd, 32'hFFFF_FFFF);
        check("valid_empty", 32'(vl), 32'h1);

        // overrun
`ifdef CSR_UART_RX_FIFO_EN
        for (int i = 0; i < 5; i++) send(8'h41 + 8'(i), 1'b1);
        csr_read(BASE, rd, vl); check("fifo_rd0", rd, 32'h0000_0241);
        csr_read(BASE, rd, vl); check("fifo_rd1", rd, 32'h0000_0042);
        csr_read(BASE, rd, vl); check("fifo_rd2", rd, 32'h0000_0043);
        csr_read(BASE, rd, vl); check("fifo_rd3", rd, 32'h0000_0044);
        csr_read(BASE, rd, vl); check("fifo_rd4", rd, 32'hFFFF_FFFF);
        csr_read(BASE, rd, vl); check("fifo_rd5", rd, 32'hFFFF_FFFF);
`else
        send(8'h41, 1'b1);
        send(8'h42, 1'b1);
        csr_read(BASE, rd, vl); check("ovr_rd0", rd, 32'h0000_0241);
        csr_read(BASE, rd, vl); check("ovr_rd1", rd, 32'hFFFF_FFFF);
`endif

        // framing error then a good byte
        send(8'h33, 1'b0);
        hold_bit(1'b1);
        hold_bit(1'b1);
        send(8'h7A, 1'b1);
        csr_read(BASE, rd, vl); check("ferr_rd", rd, 32'h0000_017A);
        csr_read(BASE, rd, vl); check("ferr_rd_empty", rd, 32'hFFFF_FFFF);

        // two-cycle glitch
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_irq", 32'(irq), 32'h0);
        csr_read(BASE, rd, vl); check("glitch_rd", rd, 32'hFFFF_FFFF);

        // reset mid-frame with a byte already buffered
        send(8'h99, 1'b1);
        hold_bit(1'b0);
        hold_bit(1'b1);
        hold_bit(1'b1);
        hold_bit(1'b0);
        rx = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_irq", 32'(irq), 32'h0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("rst_low_irq", 32'(irq), 32'h0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        send(8'h10, 1'b1);
        csr_read(BASE, rd, vl); check("rst_rd", rd, 32'h0000_0010);
        csr_read(BASE, rd, vl); check("rst_rd_empty", rd, 32'hFFFF_FFFF);

        // address miss and write do not respond or pop
        send(8'h5A, 1'b1);
        csr_read(12'hBC1, rd, vl);
        check("miss_rdata", rd, 32'h0);
        check("miss_valid", 32'(vl), 32'h0);
        bus.modify = 3'd1;
        bus.addr = BASE;
        bus.wdata = 32'h1234_5678;
        @(negedge clk);
        bus.modify = 3'd0;
        bus.addr = '0;
        check("wr_rdata", bus.rdata, 32'h0);
        check("wr_valid", 32'(bus.valid), 32'h0);
        @(negedge clk);
        check("wr_irq", 32'(irq), 32'h1);
        csr_read(BASE, rd, vl); check("wr_rd", rd, 32'h0000_005A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
